// File: rtl/div8b.sv
// Multi-cycle unsigned restoring divider for the 8085 ALU datapath.
// One quotient bit per clock behind a start/busy/done handshake.
module div8b #(
  parameter int DATASIZE = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic [DATASIZE-1:0] iA,
  input  logic [DATASIZE-1:0] iB,
  output logic [DATASIZE-1:0] oQ,
  output logic [DATASIZE-1:0] oR,
  output logic                oBusy,
  output logic                oDone,
  output logic                oDivZ
);

  localparam int CNTW = $clog2(DATASIZE);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t state;
  state_t state_nxt;

  logic [DATASIZE-1:0] a_reg;
  logic [DATASIZE-1:0] b_reg;
  logic [DATASIZE-1:0] quo;
  logic [DATASIZE-1:0] rem;
  logic [CNTW-1:0]     cnt;

  logic                accept;
  logic                last_iter;
  logic                trial_ok;
  logic [DATASIZE:0]   shifted;
  logic [DATASIZE:0]   trial;
  logic [DATASIZE-1:0] rem_nxt;
  logic [DATASIZE-1:0] quo_nxt;

  assign accept    = ((state == IDLE) || (state == DONE)) && iStart;
  assign last_iter = (cnt == '0);

  // The partial remainder never exceeds the divisor after a step, so only
  // the trial subtraction needs the extra borrow bit.
  assign shifted  = {1'b0, rem, quo[DATASIZE-1]};
  assign trial    = shifted - {1'b0, b_reg};
  assign trial_ok = ~trial[DATASIZE];
  assign rem_nxt  = trial_ok ? trial[DATASIZE-1:0] : shifted[DATASIZE-1:0];
  assign quo_nxt  = {quo[DATASIZE-2:0], trial_ok};

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart) state_nxt = LOAD;
      LOAD:    state_nxt = (b_reg == '0) ? DONE : ITER;
      ITER:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = iStart ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    oBusy = 1'b0;
    oDone = 1'b0;
    case (state)
      LOAD, ITER: oBusy = 1'b1;
      DONE:       oDone = 1'b1;
      default:    ;
    endcase
  end

  // Result registers only change on the edge that enters DONE, so they
  // hold the previous answer for the whole of the next operation.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      a_reg <= '0;
      b_reg <= '0;
      quo   <= '0;
      rem   <= '0;
      cnt   <= '0;
      oQ    <= '0;
      oR    <= '0;
      oDivZ <= 1'b0;
    end else begin
      if (accept) begin
        a_reg <= iA;
        b_reg <= iB;
      end
      case (state)
        LOAD: begin
          if (b_reg == '0) begin
            oQ    <= '1;
            oR    <= a_reg;
            oDivZ <= 1'b1;
          end else begin
            rem <= '0;
            quo <= a_reg;
            cnt <= CNTW'(DATASIZE - 1);
          end
        end
        ITER: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (last_iter) begin
            oQ    <= quo_nxt;
            oR    <= rem_nxt;
            oDivZ <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div8b.sv
// Self-checking bench for div8b: directed scenarios plus randomized operands
// checked against plain integer division.
module tb_div8b;

  logic       iClk;
  logic       iRstN;
  logic       iStart;
  logic [7:0] iA;
  logic [7:0] iB;
  logic [7:0] oQ;
  logic [7:0] oR;
  logic       oBusy;
  logic       oDone;
  logic       oDivZ;

  int vectors;
  int miscompares;

  div8b #(.DATASIZE(8)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iStart(iStart),
    .iA    (iA),
    .iB    (iB),
    .oQ    (oQ),
    .oR    (oR),
    .oBusy (oBusy),
    .oDone (oDone),
    .oDivZ (oDivZ)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic model(input int a, input int b, output int q, output int r, output bit z);
    if (b == 0) begin
      q = 255; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  // Drives a start that is accepted on the next edge; returns one step after it.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    iA = a; iB = b; iStart = 1'b1;
    step();
    iStart = 1'b0;
    iA = 8'($urandom); iB = 8'($urandom);
  endtask

  // Counts edges (accepting edge = 1) until oDone is seen, bounded.
  task automatic wait_done(output int edges, output int busy_cycles, output bit ok);
    edges = 1; busy_cycles = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (oDone) begin
        ok = 1'b1;
        return;
      end
      if (oBusy) busy_cycles++;
      step();
      edges++;
    end
  endtask

  task automatic test_reset();
    iRstN = 1'b0; iStart = 1'b0; iA = '0; iB = '0;
    step(); step();
    vectors++;
    if ({oQ, oR, oBusy, oDone, oDivZ} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got Q=%0d R=%0d busy=%b done=%b divz=%b, want all 0", oQ, oR, oBusy, oDone, oDivZ);
    end
    iRstN = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int edges, busy;
    bit ok;
    start_op(8'd100, 8'd7);
    wait_done(edges, busy, ok);
    vectors++;
    if (!ok || edges !== 10) begin
      miscompares++;
      $display("FAIL basic_latency: got ok=%b edges=%0d, want 10", ok, edges);
    end
    vectors++;
    if (busy !== 9) begin
      miscompares++;
      $display("FAIL basic_busy: got %0d busy cycles, want 9", busy);
    end
    vectors++;
    if (oQ !== 8'd14 || oR !== 8'd2 || oDivZ !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got Q=%0d R=%0d divz=%b, want Q=14 R=2 divz=0", oQ, oR, oDivZ);
    end
    step();
    vectors++;
    if (oDone !== 1'b0 || oBusy !== 1'b0 || oQ !== 8'd14 || oR !== 8'd2) begin
      miscompares++;
      $display("FAIL basic_hold: got done=%b busy=%b Q=%0d R=%0d, want 0 0 14 2", oDone, oBusy, oQ, oR);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] as [7] = '{8'd255, 8'd5, 8'd0, 8'd77, 8'd255, 8'd9, 8'd1};
    logic [7:0] bs [7] = '{8'd1, 8'd9, 8'd3, 8'd77, 8'd255, 8'd3, 8'd255};
    int edges, busy, q, r;
    bit ok, z;
    for (int i = 0; i < 7; i++) begin
      model(int'(as[i]), int'(bs[i]), q, r, z);
      start_op(as[i], bs[i]);
      wait_done(edges, busy, ok);
      vectors++;
      if (!ok || oQ !== 8'(q) || oR !== 8'(r) || oDivZ !== z) begin
        miscompares++;
        $display("FAIL boundary_%0d: %0d/%0d got Q=%0d R=%0d divz=%b ok=%b, want Q=%0d R=%0d divz=%b",
                 i, as[i], bs[i], oQ, oR, oDivZ, ok, q, r, z);
      end
      step();
    end
  endtask

  task automatic test_divz();
    int edges, busy;
    bit ok;
    start_op(8'd200, 8'd0);
    wait_done(edges, busy, ok);
    vectors++;
    if (!ok || edges !== 2) begin
      miscompares++;
      $display("FAIL divz_latency: got ok=%b edges=%0d, want 2", ok, edges);
    end
    vectors++;
    if (oQ !== 8'd255 || oR !== 8'd200 || oDivZ !== 1'b1) begin
      miscompares++;
      $display("FAIL divz_result: got Q=%0d R=%0d divz=%b, want 255 200 1", oQ, oR, oDivZ);
    end
    step();
    start_op(8'd9, 8'd3);
    vectors++;
    if (oDivZ !== 1'b1 || oQ !== 8'd255) begin
      miscompares++;
      $display("FAIL divz_hold_busy: got Q=%0d divz=%b, want 255 1", oQ, oDivZ);
    end
    wait_done(edges, busy, ok);
    vectors++;
    if (!ok || oQ !== 8'd3 || oR !== 8'd0 || oDivZ !== 1'b0) begin
      miscompares++;
      $display("FAIL divz_next: got Q=%0d R=%0d divz=%b ok=%b, want 3 0 0", oQ, oR, oDivZ, ok);
    end
    step();
  endtask

  task automatic test_ignore_start();
    int edges, busy, dones;
    bit ok;
    start_op(8'd50, 8'd5);
    step(); step(); step();
    iA = 8'd1; iB = 8'd1; iStart = 1'b1;
    step();
    iStart = 1'b0;
    wait_done(edges, busy, ok);
    vectors++;
    if (!ok || edges !== 6 || oQ !== 8'd10 || oR !== 8'd0) begin
      miscompares++;
      $display("FAIL ignore_result: got Q=%0d R=%0d edges=%0d ok=%b, want 10 0 6", oQ, oR, edges, ok);
    end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (oDone || oBusy) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL ignore_queued: got %0d busy/done cycles after completion, want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int edges, busy;
    bit ok;
    start_op(8'd100, 8'd7);
    wait_done(edges, busy, ok);
    start_op(8'd17, 8'd4);
    vectors++;
    if (oBusy !== 1'b1 || oDone !== 1'b0 || oQ !== 8'd14 || oR !== 8'd2) begin
      miscompares++;
      $display("FAIL b2b_load: got busy=%b done=%b Q=%0d R=%0d, want 1 0 14 2", oBusy, oDone, oQ, oR);
    end
    wait_done(edges, busy, ok);
    vectors++;
    if (!ok || edges !== 10 || oQ !== 8'd4 || oR !== 8'd1) begin
      miscompares++;
      $display("FAIL b2b_second: got Q=%0d R=%0d edges=%0d ok=%b, want 4 1 10", oQ, oR, edges, ok);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int edges, busy, seen;
    bit ok;
    start_op(8'd100, 8'd7);
    step(); step(); step();
    iRstN = 1'b0;
    step();
    iRstN = 1'b1;
    vectors++;
    if ({oQ, oR, oBusy, oDone, oDivZ} !== 19'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got Q=%0d R=%0d busy=%b done=%b divz=%b, want all 0", oQ, oR, oBusy, oDone, oDivZ);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (oDone || oBusy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midreset_idle: got %0d busy/done cycles, want 0", seen);
    end
    start_op(8'd9, 8'd2);
    wait_done(edges, busy, ok);
    vectors++;
    if (!ok || oQ !== 8'd4 || oR !== 8'd1) begin
      miscompares++;
      $display("FAIL midreset_next: got Q=%0d R=%0d ok=%b, want 4 1", oQ, oR, ok);
    end
    step();
  endtask

  task automatic test_random();
    int edges, busy, q, r, exp_edges;
    bit ok, z;
    logic [7:0] a, b;
    for (int n = 0; n < 1500; n++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      model(int'(a), int'(b), q, r, z);
      exp_edges = (b == 0) ? 2 : 10;
      start_op(a, b);
      wait_done(edges, busy, ok);
      vectors++;
      if (!ok || edges !== exp_edges || oQ !== 8'(q) || oR !== 8'(r) || oDivZ !== z) begin
        miscompares++;
        $display("FAIL random_%0d: %0d/%0d got Q=%0d R=%0d divz=%b edges=%0d, want Q=%0d R=%0d divz=%b edges=%0d",
                 n, a, b, oQ, oR, oDivZ, edges, q, r, z, exp_edges);
      end
      if (b != 0) begin
        vectors++;
        if (int'(oQ) * int'(b) + int'(oR) != int'(a) || oR >= b) begin
          miscompares++;
          $display("FAIL random_invariant_%0d: %0d/%0d got Q=%0d R=%0d", n, a, b, oQ, oR);
        end
      end
      if ($urandom_range(0, 1) == 0) step();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_divz();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
